fetch_pc_sequencer: RTL and testbench

//  Sequences the fetch stage: owns the PC register, issues one instruction-memory request at a time,
//  and picks the next PC by priority: redirect > BTB prediction > PC+4.

---
 rtl/fetch_pc_sequencer_pkg.sv | 13 +
 rtl/fetch_pc_sequencer_next_pc_sel.sv | 24 ++
 rtl/fetch_pc_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared fetch-sequencer types: FSM state encoding and default widths.
package fetch_pc_sequencer_pkg;

  localparam int unsigned PC_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    RESET,
    ISSUE,
    WAIT,
    HOLD
  } fetch_seq_e;

endpackage

// File: rtl/fetch_pc_sequencer_next_pc_sel.sv
// Next-PC select: redirect beats BTB prediction beats sequential PC+4.
module fetch_pc_sequencer_next_pc_sel
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                btb_hit,
  input  logic [PC_WIDTH-1:0] btb_pc,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] next_pc
);

  always_comb begin
    next_pc = pc + PC_WIDTH'(4);
    priority case (1'b1)
      redirect_valid: next_pc = redirect_pc & ~PC_WIDTH'(3);
      btb_hit:        next_pc = btb_pc;
      default:        next_pc = pc + PC_WIDTH'(4);
    endcase
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch sequencer: PC register, single-outstanding imem request FSM,
// stale-response drop and decode-facing output registers.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] pc,
  input  logic                btbHit,
  input  logic [PC_WIDTH-1:0] btbPredictedPc,
  input  logic                redirectValid,
  input  logic [PC_WIDTH-1:0] redirectPc,
  input  logic                decodeStall,
  output logic                imemReq,
  output logic [PC_WIDTH-1:0] imemAddr,
  input  logic                imemReqReady,
  input  logic                imemRspValid,
  input  logic [31:0]         imemRspData,
  output logic                fetchValid,
  output logic [PC_WIDTH-1:0] fetchPc,
  output logic [31:0]         fetchInsn,
  output logic                fetchPredTaken
);

  fetch_seq_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                drop_q, drop_d;
  logic                fv_q, fv_d;
  logic [PC_WIDTH-1:0] fpc_q, fpc_d;
  logic [31:0]         finsn_q, finsn_d;
  logic                fpred_q, fpred_d;
  logic [PC_WIDTH-1:0] sel_pc;
  logic                accept;
  logic                redir;

  fetch_pc_sequencer_next_pc_sel #(
    .PC_WIDTH(PC_WIDTH)
  ) u_sel (
    .redirect_valid(redirectValid),
    .redirect_pc   (redirectPc),
    .btb_hit       (btbHit),
    .btb_pc        (btbPredictedPc),
    .pc            (pc_q),
    .next_pc       (sel_pc)
  );

  assign accept = (state_q == ISSUE) && imemReqReady;
  assign redir  = redirectValid && (state_q != RESET);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    fv_d    = fv_q;
    fpc_d   = fpc_q;
    finsn_d = finsn_q;
    fpred_d = fpred_q;
    if (fv_q && !decodeStall) fv_d = 1'b0;
    unique case (state_q)
      RESET: state_d = ISSUE;
      ISSUE: begin
        // a response seen here can only be the stale one being dropped
        if (drop_q && imemRspValid) drop_d = 1'b0;
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (imemRspValid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            fv_d    = 1'b1;
            fpc_d   = pc_q;
            finsn_d = imemRspData;
            fpred_d = btbHit;
            pc_d    = sel_pc;
            state_d = decodeStall ? HOLD : ISSUE;
          end
        end
      end
      HOLD: if (!decodeStall) state_d = ISSUE;
      default: state_d = RESET;
    endcase
    if (redir) begin
      pc_d    = sel_pc;
      fv_d    = 1'b0;
      fpc_d   = fpc_q;
      finsn_d = finsn_q;
      fpred_d = fpred_q;
      state_d = ISSUE;
      drop_d  = ((state_q == WAIT) && !imemRspValid) ||
                ((state_q == ISSUE) &&
                 (accept || (drop_q && !imemRspValid)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      pc_q    <= RESET_VECTOR;
      drop_q  <= 1'b0;
      fv_q    <= 1'b0;
      fpc_q   <= '0;
      finsn_q <= '0;
      fpred_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      fv_q    <= fv_d;
      fpc_q   <= fpc_d;
      finsn_q <= finsn_d;
      fpred_q <= fpred_d;
    end
  end

  assign pc             = pc_q;
  assign imemReq        = (state_q == ISSUE);
  assign imemAddr       = pc_q;
  assign fetchValid     = fv_q;
  assign fetchPc        = fpc_q;
  assign fetchInsn      = finsn_q;
  assign fetchPredTaken = fpred_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Scoreboard bench: expected requests/deliveries queued with stimulus,
// compared as the sequencer issues and delivers.
`timescale 1ns/1ps
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        btbHit;
  logic [31:0] btbPredictedPc;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        decodeStall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReqReady;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        fetchValid;
  logic [31:0] fetchPc;
  logic [31:0] fetchInsn;
  logic        fetchPredTaken;

  fetch_pc_sequencer #(
    .PC_WIDTH(32),
    .RESET_VECTOR(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .btbHit        (btbHit),
    .btbPredictedPc(btbPredictedPc),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .decodeStall   (decodeStall),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemReqReady  (imemReqReady),
    .imemRspValid  (imemRspValid),
    .imemRspData   (imemRspData),
    .fetchValid    (fetchValid),
    .fetchPc       (fetchPc),
    .fetchInsn     (fetchInsn),
    .fetchPredTaken(fetchPredTaken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        pred;
  } fexp_t;

  logic [31:0] exp_addr_q[$];
  fexp_t       exp_fetch_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // BTB model: one tag/target pair
  logic        btb_en  = 1'b0;
  logic [31:0] btb_tag = '0;
  logic [31:0] btb_tgt = '0;
  assign btbHit         = btb_en && (pc == btb_tag);
  assign btbPredictedPc = btb_tgt;

  // Memory model: single outstanding, fixed latency, gated by allowance
  logic        busy = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [31:0] mem_addr = '0;
  int          cnt = 0;
  int          lat = 1;
  int          n_allowed = 0;
  logic        acc_n = 1'b0;
  logic [31:0] acc_addr_n = '0;

  assign imemReqReady = !busy && (n_allowed > 0);
  assign imemRspValid = rsp_valid;
  assign imemRspData  = rsp_data;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    acc_n      = imemReq && imemReqReady;
    acc_addr_n = imemAddr;
    if (acc_n) begin
      if (exp_addr_q.size() == 0) chk("unexp_req", {31'b0, imemReq}, 32'h0);
      else chk("imem_addr", imemAddr, exp_addr_q.pop_front());
    end
    if (fetchValid && !decodeStall) begin
      if (exp_fetch_q.size() == 0) begin
        chk("unexp_fetch", {31'b0, fetchValid}, 32'h0);
      end else begin
        fexp_t e;
        e = exp_fetch_q.pop_front();
        chk("fetch_pc", fetchPc, e.pc);
        chk("fetch_insn", fetchInsn, e.insn);
        chk("fetch_pred", {31'b0, fetchPredTaken}, {31'b0, e.pred});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rsp_valid) begin
      rsp_valid = 1'b0;
      busy      = 1'b0;
    end
    if (acc_n) begin
      busy     = 1'b1;
      mem_addr = acc_addr_n;
      n_allowed--;
      if (lat <= 1) begin
        rsp_valid = 1'b1;
        rsp_data  = insn_of(mem_addr);
      end else begin
        cnt = lat - 1;
      end
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = insn_of(mem_addr);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_addr(input logic [31:0] a);
    exp_addr_q.push_back(a);
    n_allowed++;
  endtask

  task automatic push_fetch(input logic [31:0] p, input logic pr);
    fexp_t e;
    e.pc   = p;
    e.insn = insn_of(p);
    e.pred = pr;
    exp_fetch_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_addr_q.size() == 0 && exp_fetch_q.size() == 0 && !busy) break;
      step();
    end
    chk("drain_pending", 32'(exp_addr_q.size() + exp_fetch_q.size()), 32'h0);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 50; i++) begin
      if (busy) break;
      step();
    end
    chk("wait_busy", {31'b0, busy}, 32'h1);
  endtask

  task automatic wait_fv();
    for (int i = 0; i < 50; i++) begin
      if (fetchValid) break;
      step();
    end
    chk("wait_fv", {31'b0, fetchValid}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = '0;
    decodeStall   = 1'b0;
    step(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imemReq}, 32'h0);
    chk("rst_fv", {31'b0, fetchValid}, 32'h0);
    chk("rst_fpc", fetchPc, 32'h0);
    chk("rst_finsn", fetchInsn, 32'h0);
    chk("rst_fpred", {31'b0, fetchPredTaken}, 32'h0);

    // sequential fetch with a BTB hit on 0x8
    btb_en  = 1'b1;
    btb_tag = 32'h8;
    btb_tgt = 32'h100;
    push_addr(32'h0);
    push_addr(32'h4);
    push_addr(32'h8);
    push_addr(32'h100);
    push_fetch(32'h0, 1'b0);
    push_fetch(32'h4, 1'b0);
    push_fetch(32'h8, 1'b1);
    push_fetch(32'h100, 1'b0);
    rst = 1'b0;
    drain();
    btb_en = 1'b0;

    // redirect while waiting on a 3-cycle response
    lat = 3;
    push_addr(32'h104);
    wait_busy();
    redirectValid = 1'b1;
    redirectPc    = 32'h40;
    step();
    redirectValid = 1'b0;
    chk("redir_wait_pc", pc, 32'h40);
    push_addr(32'h40);
    push_fetch(32'h40, 1'b0);
    drain();

    // decode back-pressure holds the outputs
    decodeStall = 1'b1;
    push_addr(32'h44);
    push_fetch(32'h44, 1'b0);
    wait_fv();
    for (int i = 0; i < 4; i++) begin
      chk("hold_fv", {31'b0, fetchValid}, 32'h1);
      chk("hold_fpc", fetchPc, 32'h44);
      chk("hold_insn", fetchInsn, insn_of(32'h44));
      chk("hold_req", {31'b0, imemReq}, 32'h0);
      step();
    end
    decodeStall = 1'b0;
    push_addr(32'h48);
    push_fetch(32'h48, 1'b0);
    drain();

    // redirect in HOLD overrides the stall and aligns the target
    decodeStall = 1'b1;
    push_addr(32'h4C);
    wait_fv();
    redirectValid = 1'b1;
    redirectPc    = 32'h83;
    step();
    redirectValid = 1'b0;
    chk("redir_hold_fv", {31'b0, fetchValid}, 32'h0);
    chk("redir_hold_pc", pc, 32'h80);
    decodeStall = 1'b0;
    push_addr(32'h80);
    push_fetch(32'h80, 1'b0);
    drain();

    // PC+4 wraps at the top of the address space
    lat = 1;
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFFC;
    step();
    redirectValid = 1'b0;
    push_addr(32'hFFFF_FFFC);
    push_addr(32'h0);
    push_fetch(32'hFFFF_FFFC, 1'b0);
    push_fetch(32'h0, 1'b0);
    drain();
    chk("wrap_pc", pc, 32'h4);

    // reset mid-transaction; the late response must be ignored
    lat = 3;
    push_addr(32'h4);
    wait_busy();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_fv", {31'b0, fetchValid}, 32'h0);
    push_addr(32'h0);
    push_fetch(32'h0, 1'b0);
    drain();
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
